ln_taylor: RTL and testbench
============================

# ln_taylor

Iterative natural-logarithm unit: computes ln(x) for a real operand, one series term per clock. It is the inverse companion of the team's Taylor-series exponential block in the same floating-point math library, and has the same start/done handshake. Range reduction normalises x to m·2^k with m in [1,2). The mantissa term uses the atanh series: ln(m) = 2·Σ y^(2n+1)/(2n+1), with y = (m−1)/(m+1).

## Interface
- N_TERMS, 20: number of atanh series terms summed (≥1).
- MAX_SHIFT, 1100: maximum |k| normalisation steps before the operand is declared invalid (catches +inf/NaN).
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- x  input  real  operand; sampled on the accepting edge only.
- busy  output  1  high from the edge after acceptance until done is asserted.
- done  output  1  one-cycle completion pulse.
- err  output  1  operand invalid (x ≤ 0.0, inf, NaN); valid while done high, held until next acceptance.
- result  output  real  ln(x); valid while done high, held until next completion.

## Operation
- Reset values: done=0, busy=0, err=0, result=0.0, state IDLE, k=0.
- Internal: m (real), y2 (real), pw (real), sum (real), k (signed int), n (int).
- States: IDLE, NORM, PREP, CALC, DONE.
- IDLE: done<=0. On start, clear err. If x ≤ 0.0: err<=1, result<=0.0, go to DONE. Otherwise m<=x, k<=0, busy<=1, go to NORM.
- NORM, one step per cycle:
  - m ≥ 2.0: m<=m/2.0, k<=k+1.
  - m < 1.0: m<=m·2.0, k<=k−1.
  - Otherwise go to PREP.
  - If |k| reaches MAX_SHIFT before m is in range: err<=1, result<=0.0, go to DONE.
- PREP: pw<=(m−1)/(m+1), y2<=((m−1)/(m+1))², sum<=0.0, n<=0, go to CALC.
- CALC, each cycle:
  - sum<=sum+pw/(2n+1), pw<=pw·y2, n<=n+1.
  - When n==N_TERMS−1: result<=2.0·(sum+pw/(2n+1)) + k·LN2, where LN2 = 0.6931471805599453. Go to DONE.
- DONE: done<=1, busy<=0, go to IDLE.
- Undefined state encoding goes to IDLE.
- start while busy or in DONE is ignored; there is no queueing.
- y lies in [0, 1/3), so the truncation error is below (1/9)^N_TERMS. With the default N_TERMS this is at full double precision.

## Timing
- Acceptance edge is E0. NORM occupies |k|+1 edges, PREP 1, CALC N_TERMS, DONE 1.
- Valid operand: done is high in the cycle after edge E0+|k|+N_TERMS+3.
  - For x in [1,2) that is edge N_TERMS+3 (23 with defaults).
- Invalid operand (x ≤ 0): done is high after edge E0+1.
- Overflow or NaN: done is high after edge E0+MAX_SHIFT+1.
- result updates one edge before done rises and is stable while done is high.
- done is cleared on the following edge.
- busy falls on the same edge that done rises.
- start high in the same cycle done is high is accepted, since the state is already IDLE. This gives back-to-back operation with no dead cycle.
- rst asserted mid-operation (any state) immediately forces reset values. Partial results are discarded, and no done pulse is produced for the aborted operation.

## Test plan
- x=1.0, start 1 cycle → done after edge 23, result=0.0 exactly, err=0, busy high edges 1–22.
- x=2.0 → k=1, m=1.0, result=0.6931471805599453 (±1e-15), done after edge 24.
- x=2.718281828459045 → result=1.0 ±1e-12; x=0.125 → k=−3, result=−2.0794415416798357 ±1e-12, done after edge 26.
- x=0.0, then x=−1.0 → err=1, result=0.0, done after edge 1 each; the next valid start clears err.
- start pulsed during CALC with x=5.0 → ignored, result of first operand unchanged. start held high during done → second operation accepted with no idle cycle.
- rst asserted for 1 cycle mid-CALC → done/busy/err=0, result=0.0, no done pulse. A fresh start of x=4.0 → 1.3862943611198906 ±1e-12.

Source files
------------

// File: rtl/ln_taylor.sv
// ln_taylor: iterative natural logarithm, one atanh series term per clock.
// Normalises x to m*2^k with m in [1,2), then sums 2*atanh((m-1)/(m+1)).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only in IDLE
//   x      in   real operand, sampled on the accepting edge
//   busy   out  operation in flight
//   done   out  one-cycle completion pulse
//   err    out  operand invalid (x <= 0, inf, NaN)
//   result out  ln(x), held until the next completion
module ln_taylor #(
    parameter int N_TERMS   = 20,
    parameter int MAX_SHIFT = 1100
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  real  x,
    output logic busy,
    output logic done,
    output logic err,
    output real  result
);

    localparam real LN2 = 0.6931471805599453;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        PREP,
        CALC,
        DONE
    } state_t;

    state_t state_q;
    real    m_q;
    real    y2_q;
    real    pw_q;
    real    sum_q;
    real    result_q;
    int     k_q;
    int     n_q;
    logic   busy_q;
    logic   done_q;
    logic   err_q;

    real    y_d;
    real    term_d;
    int     k_d;
    logic   in_rng_d;

    always_comb begin
        y_d      = (m_q - 1.0) / (m_q + 1.0);
        term_d   = pw_q / real'(2 * n_q + 1);
        // NaN fails both bounds, so it is treated as out of range and
        // keeps halving until the shift limit flags it as invalid.
        in_rng_d = (m_q >= 1.0) && (m_q < 2.0);
        k_d      = (m_q < 1.0) ? k_q - 1 : k_q + 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= 0.0;
            y2_q     <= 0.0;
            pw_q     <= 0.0;
            sum_q    <= 0.0;
            result_q <= 0.0;
            k_q      <= 0;
            n_q      <= 0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (x <= 0.0) begin
                            err_q    <= 1'b1;
                            result_q <= 0.0;
                            state_q  <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            m_q     <= x;
                            k_q     <= 0;
                            busy_q  <= 1'b1;
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (in_rng_d) begin
                        state_q <= PREP;
                    end else if (k_d >= MAX_SHIFT || k_d <= -MAX_SHIFT) begin
                        err_q    <= 1'b1;
                        result_q <= 0.0;
                        state_q  <= DONE;
                    end else begin
                        m_q <= (m_q < 1.0) ? m_q * 2.0 : m_q / 2.0;
                        k_q <= k_d;
                    end
                end
                PREP: begin
                    pw_q    <= y_d;
                    y2_q    <= y_d * y_d;
                    sum_q   <= 0.0;
                    n_q     <= 0;
                    state_q <= CALC;
                end
                CALC: begin
                    sum_q <= sum_q + term_d;
                    pw_q  <= pw_q * y2_q;
                    n_q   <= n_q + 1;
                    if (n_q == N_TERMS - 1) begin
                        result_q <= 2.0 * (sum_q + term_d) + real'(k_q) * LN2;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_ln_taylor.sv
// tb_ln_taylor: directed scoreboard bench for ln_taylor.
// Expected results are queued at launch and compared at done.
module tb_ln_taylor;

    localparam real LN2 = 0.6931471805599453;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    real  x = 0.0;
    logic busy;
    logic done;
    logic err;
    real  result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        real  e;
        real  tol;
        logic er;
        int   lat;
        logic bz;
    } exp_t;

    exp_t sb[$];

    ln_taylor #(.N_TERMS(20), .MAX_SHIFT(1100)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp, input real tol);
        real d;
        d = obs - exp;
        checks++;
        assert (d <= tol && -d <= tol) else begin
            errors++;
            $error("FAIL %s observed %.17g expected %.17g tol %g", tag, obs, exp, tol);
        end
    endtask

    task automatic launch(input real xv, input real e, input real tol,
                          input logic er, input int lat, input logic bz);
        exp_t t;
        t.e = e;
        t.tol = tol;
        t.er = er;
        t.lat = lat;
        t.bz = bz;
        sb.push_back(t);
        start = 1'b1;
        x = xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = 0.0;
        chk_bit("done_clear_at_accept", done, 1'b0);
        chk_bit("busy_after_accept", busy, bz);
    endtask

    task automatic wait_done(input int pulse_at);
        exp_t t;
        int   cyc;
        int   badbusy;
        logic got;
        cyc = 0;
        badbusy = 0;
        got = 1'b0;
        chk_int("sb_nonempty", sb.size(), sb.size() > 0 ? sb.size() : 1);
        if (sb.size() > 0) t = sb[0];
        for (int i = 1; i <= 2000; i++) begin
            if (i == pulse_at) begin
                start = 1'b1;
                x = 5.0;
            end else if (i == pulse_at + 1) begin
                start = 1'b0;
                x = 0.0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = i;
                got = 1'b1;
                break;
            end
            if (busy !== t.bz) badbusy++;
        end
        chk_bit("done_seen", got, 1'b1);
        if (got) begin
            if (sb.size() > 0) t = sb.pop_front();
            chk_int("latency", cyc, t.lat);
            chk_bit("err", err, t.er);
            chk_real("result", result, t.e, t.tol);
            chk_bit("busy_at_done", busy, 1'b0);
            chk_int("busy_during_op", badbusy, 0);
        end
    endtask

    initial begin
        real xinf;
        real xnan;
        int  spurious;
        xinf = $bitstoreal(64'h7FF0000000000000);
        xnan = $bitstoreal(64'h7FF8000000000000);

        repeat (2) @(posedge clk);
        #1;
        chk_bit("reset_done", done, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_err", err, 1'b0);
        chk_real("reset_result", result, 0.0, 0.0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        launch(1.0, 0.0, 0.0, 1'b0, 23, 1'b1);
        wait_done(-5);
        @(posedge clk);
        #1;
        chk_bit("done_one_cycle", done, 1'b0);
        chk_real("result_held", result, 0.0, 0.0);

        launch(2.0, LN2, 1e-15, 1'b0, 24, 1'b1);
        wait_done(-5);
        launch(2.718281828459045, 1.0, 1e-12, 1'b0, 24, 1'b1);
        wait_done(-5);
        launch(0.125, -2.0794415416798357, 1e-12, 1'b0, 26, 1'b1);
        wait_done(-5);
        launch(0.0, 0.0, 0.0, 1'b1, 1, 1'b0);
        wait_done(-5);
        launch(-1.0, 0.0, 0.0, 1'b1, 1, 1'b0);
        wait_done(-5);
        launch(10.0, 2.302585092994046, 1e-12, 1'b0, 26, 1'b1);
        wait_done(-5);
        launch(xinf, 0.0, 0.0, 1'b1, 1101, 1'b1);
        wait_done(-5);
        launch(xnan, 0.0, 0.0, 1'b1, 1101, 1'b1);
        wait_done(-5);

        // start with x=5.0 pulsed mid-CALC must be ignored
        launch(3.0, 1.0986122886681098, 1e-12, 1'b0, 24, 1'b1);
        wait_done(10);
        @(posedge clk);
        #1;
        chk_bit("ignored_start_no_op", busy, 1'b0);

        // back-to-back: second start driven while done is high
        launch(2.0, LN2, 1e-15, 1'b0, 24, 1'b1);
        wait_done(-5);
        launch(4.0, 1.3862943611198906, 1e-12, 1'b0, 25, 1'b1);
        wait_done(-5);

        // reset mid-CALC aborts without a done pulse
        start = 1'b1;
        x = 1.0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_bit("abort_done", done, 1'b0);
        chk_bit("abort_busy", busy, 1'b0);
        chk_bit("abort_err", err, 1'b0);
        chk_real("abort_result", result, 0.0, 0.0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) spurious++;
        end
        chk_int("abort_no_done", spurious, 0);

        launch(4.0, 1.3862943611198906, 1e-12, 1'b0, 25, 1'b1);
        wait_done(-5);

        chk_int("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
